// File: rtl/fifo_ctrl_memoria_pkg.sv
// Shared sizing and default thresholds for the memoria FIFO controller and its top level.
package fifo_ctrl_memoria_pkg;

    localparam int unsigned DATA_WIDTH      = 10;
    localparam int unsigned ADDRESS_WIDTH   = 8;
    localparam int unsigned DEPTH           = 1 << ADDRESS_WIDTH;
    localparam int unsigned CNT_WIDTH       = ADDRESS_WIDTH + 1;
    localparam int unsigned UMBRAL_ALTO_DEF = DEPTH - 2;
    localparam int unsigned UMBRAL_BAJO_DEF = 1;

endpackage

// File: rtl/fifo_ctrl_memoria.sv
// Push/pop front end for the memoria storage block: strobes, occupancy, flags,
// sticky error and a one-cycle-latency valid qualifier on returned read data.
module fifo_ctrl_memoria
    import fifo_ctrl_memoria_pkg::*;
#(
    parameter int unsigned data_width    = DATA_WIDTH,
    parameter int unsigned address_width = ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [data_width-1:0]    data_in,
    input  logic [address_width:0]   umbral_alto,
    input  logic [address_width:0]   umbral_bajo,
    input  logic [data_width-1:0]    memo_data_out,
    output logic                     wrmem_enable,
    output logic                     rdmem_enable,
    output logic [data_width-1:0]    memo_data_in,
    output logic [data_width-1:0]    data_out,
    output logic                     data_valid,
    output logic [address_width:0]   count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     error
);

    localparam int unsigned CW    = address_width + 1;
    localparam int unsigned DEPTH_L = 1 << address_width;

    logic overflow;
    logic underflow;

    // Flags decode the registered count directly.
    assign fifo_full    = (count == CW'(DEPTH_L));
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= umbral_alto);
    assign almost_empty = (count <= umbral_bajo);

    // A pop at full frees the slot the simultaneous push reuses.
    assign wrmem_enable = push & (~fifo_full | pop);
    assign rdmem_enable = pop & ~fifo_empty;
    assign memo_data_in = data_in;

    assign overflow  = push & fifo_full & ~pop;
    assign underflow = pop & fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            data_valid <= 1'b0;
            data_out   <= '0;
            error      <= 1'b0;
        end else begin
            case ({wrmem_enable, rdmem_enable})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            data_valid <= rdmem_enable;
            // memoria presents the head word combinationally in the read cycle.
            if (rdmem_enable) begin
                data_out <= memo_data_out;
            end
            if (overflow | underflow) begin
                error <= 1'b1;
            end
        end
    end

endmodule
